tx_rd_req_arbiter: RTL
======================

# tx_rd_req_arbiter

Arbitrates the single host memory-read request path between the DMA engine's primary chunk requester and the retry monitor's re-issue requester. Allocates PCIe tags to primary requests from a free pool and returns tags to the pool on completion-done notifications. Forwards exactly one request at a time to the MRd TLP builder over a req/ack handshake. Sits between the TX DMA engine/retry monitor and the TRN transmit TLP generator, in the trn_clk domain.

## Interface
- NUM_TAGS, 4, number of tags in the pool (1..16); tags 0..NUM_TAGS-1 are valid
- RETRY_BURST_MAX, 4, maximum consecutive retry grants while a primary request is eligible (1..15)

- trn_clk  in  1  clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- rd_req  in  1  primary request; held until rd_ack
- rd_addr  in  64  primary host byte address
- rd_qwords  in  9  primary length in qwords
- rd_ack  out  1  one-cycle pulse; primary request accepted and issued
- rd_tag  out  4  allocated tag; valid only while rd_ack=1
- retry_req  in  1  retry request; held until retry_ack
- retry_addr  in  64  retry host byte address
- retry_tag  in  4  tag being retried (already owned)
- retry_dwords  in  10  retry length in dwords
- retry_ack  out  1  one-cycle pulse; retry issued
- mrd_req  out  1  request to TLP builder; held until mrd_ack
- mrd_addr  out  64  address to builder
- mrd_tag  out  4  tag to builder
- mrd_dwords  out  10  length in dwords to builder
- mrd_ack  in  1  builder accepted the request
- tag_free_valid  in  1  one-cycle pulse; all data for tag_free_tag received
- tag_free_tag  in  4  tag to release
- tags_busy  out  NUM_TAGS  bit i = tag i allocated

## Operation
- Reset values: rd_ack=0, retry_ack=0, mrd_req=0, mrd_addr=0, mrd_tag=0, mrd_dwords=0, rd_tag=0, tags_busy=0, burst_cnt=0, state=S_IDLE.
- Primary eligible = rd_req=1 and at least one tags_busy bit clear (registered vector).
- S_IDLE:
  - if retry_req and (not primary eligible or burst_cnt < RETRY_BURST_MAX): grant retry; latch retry_addr/retry_tag/retry_dwords into mrd_*; burst_cnt <= burst_cnt+1 (saturating); tags_busy unchanged.
  - else if primary eligible: grant primary; allocate lowest-index clear tag; set its busy bit; latch rd_addr, tag, {rd_qwords,1'b0} into mrd_*; burst_cnt <= 0.
  - else: burst_cnt <= 0 if retry_req=0.
  - on any grant: mrd_req <= 1, go S_ISSUE.
- S_ISSUE: hold mrd_req and mrd_* stable; on mrd_ack=1: mrd_req <= 0; pulse rd_ack (rd_tag=mrd_tag) or retry_ack per granted source; go S_DONE.
- S_DONE: one cycle, acks return to 0; requester drops/changes its request; go S_IDLE.
- Tag release: tag_free_valid=1 with tag_free_tag < NUM_TAGS clears that busy bit next cycle. Release of an already-clear tag or an out-of-range tag is ignored.
- Release and allocation in the same cycle: both take effect. A tag freed in cycle n is not allocatable before the S_IDLE decision in cycle n+1.
- rd_qwords=0 is forwarded as mrd_dwords=0 unchanged; the builder encodes it.
- Retry grants never consume tags; a retry_tag whose busy bit is clear is still forwarded.

## Timing
- Request sampled in S_IDLE at cycle 0 -> mrd_req=1 from cycle 1.
- mrd_ack seen at cycle k -> mrd_req=0 and ack pulse high in cycle k+1 -> S_DONE in k+1, S_IDLE in k+2. Earliest next mrd_req is k+3.
- mrd_ack while in S_IDLE/S_DONE is ignored.
- Reset in any state: takes effect next edge; mrd_req drops, all tags freed, no ack issued for the in-flight request.
- Fairness: with both requesters continuously active and tags free, the grant pattern is RETRY_BURST_MAX retries then one primary, repeating.

## Test plan
- Single primary: rd_req, addr 0x1000, qwords 16, mrd_ack 2 cycles after mrd_req -> mrd_tag=0, mrd_dwords=32; rd_ack pulses once with rd_tag=0; tags_busy=4'b0001.
- Tag exhaustion: 4 primaries with no releases -> tags 0,1,2,3; 5th rd_req held and not granted; tag_free_valid tag 2 -> 5th granted tag 2 two cycles later.
- Retry priority and burst: retry_req and rd_req held continuously, RETRY_BURST_MAX=4 -> grant order R,R,R,R,P,R,R,R,R,P; tags_busy is unchanged by retries.
- Simultaneous release and allocate: tags 0-2 busy, free tag 0 in the same cycle that a primary is granted -> allocated tag 3; tags_busy=4'b1110.
- Invalid release: free tag 9 and free an idle tag -> tags_busy unchanged.
- Reset mid-issue: assert reset while in S_ISSUE -> mrd_req=0 next cycle, tags_busy=0, no rd_ack; the next rd_req is allocated tag 0.

Source files
------------

// File: rtl/tx_rd_req_arbiter.sv
// Host memory-read request arbiter: shares one MRd builder handshake between the
// primary chunk requester (tag-allocating) and the retry re-issue requester.
module tx_rd_req_arbiter #(
   parameter int NUM_TAGS        = 4,
   parameter int RETRY_BURST_MAX = 4
) (
   input  logic                trn_clk,
   input  logic                reset,
   input  logic                rd_req,
   input  logic [63:0]         rd_addr,
   input  logic [8:0]          rd_qwords,
   output logic                rd_ack,
   output logic [3:0]          rd_tag,
   input  logic                retry_req,
   input  logic [63:0]         retry_addr,
   input  logic [3:0]          retry_tag,
   input  logic [9:0]          retry_dwords,
   output logic                retry_ack,
   output logic                mrd_req,
   output logic [63:0]         mrd_addr,
   output logic [3:0]          mrd_tag,
   output logic [9:0]          mrd_dwords,
   input  logic                mrd_ack,
   input  logic                tag_free_valid,
   input  logic [3:0]          tag_free_tag,
   output logic [NUM_TAGS-1:0] tags_busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]          state_r;
   logic [3:0]          burst_cnt_r;
   logic                grant_primary_r;
   logic [3:0]          free_tag_s;
   logic                free_any_s;
   logic                prim_elig_s;
   logic                retry_win_s;
   logic                alloc_en_s;
   logic [NUM_TAGS-1:0] release_mask_s;
   logic [NUM_TAGS-1:0] alloc_mask_s;

   // Lowest-index clear tag of the registered busy vector.
   always_comb begin
      free_tag_s = 4'd0;
      free_any_s = 1'b0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         free_tag_s = tags_busy[i] ? free_tag_s : 4'(i);
         free_any_s = free_any_s | ~tags_busy[i];
      end
   end

   assign prim_elig_s = rd_req & free_any_s;
   assign retry_win_s = retry_req & (~prim_elig_s | (burst_cnt_r < 4'(RETRY_BURST_MAX)));
   assign alloc_en_s  = (state_r == S_IDLE) & ~retry_win_s & prim_elig_s;

   // Release and allocation masks; out-of-range release tags never match a bit.
   always_comb begin
      release_mask_s = {NUM_TAGS{1'b0}};
      alloc_mask_s   = {NUM_TAGS{1'b0}};
      for (int i = 0; i < NUM_TAGS; i++) begin
         release_mask_s[i] = tag_free_valid & (tag_free_tag == 4'(i));
         alloc_mask_s[i]   = alloc_en_s & (free_tag_s == 4'(i));
      end
   end

   // Tag pool: a release and an allocation in the same cycle both take effect.
   always_ff @(posedge trn_clk) begin
      if (reset) begin
         tags_busy <= {NUM_TAGS{1'b0}};
      end else begin
         tags_busy <= (tags_busy & ~release_mask_s) | alloc_mask_s;
      end
   end

   // Grant / issue / done sequencer with retry burst accounting.
   always_ff @(posedge trn_clk) begin
      if (reset) begin
         state_r         <= S_IDLE;
         burst_cnt_r     <= 4'd0;
         grant_primary_r <= 1'b0;
         rd_ack          <= 1'b0;
         rd_tag          <= 4'd0;
         retry_ack       <= 1'b0;
         mrd_req         <= 1'b0;
         mrd_addr        <= 64'd0;
         mrd_tag         <= 4'd0;
         mrd_dwords      <= 10'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (retry_win_s) begin
                  mrd_req         <= 1'b1;
                  mrd_addr        <= retry_addr;
                  mrd_tag         <= retry_tag;
                  mrd_dwords      <= retry_dwords;
                  grant_primary_r <= 1'b0;
                  burst_cnt_r     <= (burst_cnt_r == 4'hF) ? 4'hF : burst_cnt_r + 4'd1;
                  state_r         <= S_ISSUE;
               end else if (prim_elig_s) begin
                  mrd_req         <= 1'b1;
                  mrd_addr        <= rd_addr;
                  mrd_tag         <= free_tag_s;
                  mrd_dwords      <= {rd_qwords, 1'b0};
                  grant_primary_r <= 1'b1;
                  burst_cnt_r     <= 4'd0;
                  state_r         <= S_ISSUE;
               end else if (!retry_req) begin
                  burst_cnt_r     <= 4'd0;
               end else begin
                  burst_cnt_r     <= burst_cnt_r;
               end
            end
            S_ISSUE: begin
               if (mrd_ack) begin
                  mrd_req   <= 1'b0;
                  rd_ack    <= grant_primary_r;
                  retry_ack <= ~grant_primary_r;
                  rd_tag    <= grant_primary_r ? mrd_tag : rd_tag;
                  state_r   <= S_DONE;
               end else begin
                  state_r   <= S_ISSUE;
               end
            end
            S_DONE: begin
               rd_ack    <= 1'b0;
               retry_ack <= 1'b0;
               state_r   <= S_IDLE;
            end
            default: begin
               rd_ack    <= 1'b0;
               retry_ack <= 1'b0;
               mrd_req   <= 1'b0;
               state_r   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
